i2s_serializer: RTL and testbench

I2S_SERIALIZER -- requirements
Module: i2s_serializer

---
 rtl/i2s_serializer.sv | 165 ++++++++++++++++
 tb/tb_i2s_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_serializer.sv
// I2S transmitter: a holding register feeds left/right 24-bit shift registers that are
// serialized MSB first into 32-bit slots. Build option: I2S_ZERO_ON_UNDERRUN_EN (silence on underrun).
module i2s_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        LRCLK,
    input  logic [23:0] lft_in,
    input  logic [23:0] rht_in,
    input  logic        vld,
    output logic        rdy,
    output logic        SDin,
    output logic        frm_strt,
    output logic        undrn
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } slot_e;

    typedef struct packed {
        logic [23:0] lft;
        logic [23:0] rht;
    } pair_t;

    localparam logic [4:0] DATA_BITS = 5'd24;
    localparam logic [4:0] CNT_MAX   = 5'd31;

    logic        sclk_q, lrclk_q;
    logic        sclk_fall, lrclk_fall, lrclk_rise, accept;
    pair_t       hold_q, hold_d;
    logic        full_q, full_d;
    logic        rdy_q, rdy_d;
    logic [23:0] sh_l_q, sh_l_d;
    logic [23:0] sh_r_q, sh_r_d;
    logic [4:0]  cnt_q, cnt_d;
    slot_e       state_q, state_d;
    logic        sdin_q, sdin_d;
    logic        frm_strt_q, frm_strt_d;
    logic        undrn_q, undrn_d;
`ifndef I2S_ZERO_ON_UNDERRUN_EN
    pair_t       prev_q, prev_d;
`endif

    assign sclk_fall  = sclk_q & ~SCLK;
    assign lrclk_fall = lrclk_q & ~LRCLK;
    assign lrclk_rise = ~lrclk_q & LRCLK;
    assign accept     = vld & rdy_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        hold_d     = hold_q;
        full_d     = full_q;
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        sdin_d     = sdin_q;
        frm_strt_d = lrclk_fall;
        undrn_d    = lrclk_fall & ~full_q;
`ifndef I2S_ZERO_ON_UNDERRUN_EN
        prev_d     = prev_q;
`endif

        // A load empties the holding register, but a pair accepted in the same cycle refills it.
        if (lrclk_fall && full_q) begin
            full_d = 1'b0;
        end
        if (accept) begin
            hold_d.lft = lft_in;
            hold_d.rht = rht_in;
            full_d     = 1'b1;
        end
        rdy_d = ~full_d;

        if (lrclk_fall) begin
            state_d = ST_LEFT;
            cnt_d   = '0;
            if (sclk_fall) begin
                sdin_d = 1'b0;
            end
            if (full_q) begin
                sh_l_d = hold_q.lft;
                sh_r_d = hold_q.rht;
`ifndef I2S_ZERO_ON_UNDERRUN_EN
                prev_d = hold_q;
`endif
            end else begin
`ifdef I2S_ZERO_ON_UNDERRUN_EN
                sh_l_d = '0;
                sh_r_d = '0;
`else
                sh_l_d = prev_q.lft;
                sh_r_d = prev_q.rht;
`endif
            end
        end else if (lrclk_rise) begin
            cnt_d = '0;
            if (state_q != ST_IDLE) begin
                state_d = ST_RIGHT;
            end
            if (sclk_fall) begin
                sdin_d = 1'b0;
            end
        end else if (sclk_fall) begin
            if (state_q == ST_IDLE || cnt_q >= DATA_BITS) begin
                sdin_d = 1'b0;
            end else if (state_q == ST_RIGHT) begin
                sdin_d = sh_r_q[23];
                sh_r_d = {sh_r_q[22:0], 1'b0};
            end else begin
                sdin_d = sh_l_q[23];
                sh_l_d = {sh_l_q[22:0], 1'b0};
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sclk_q     <= 1'b1;
            lrclk_q    <= 1'b1;
            hold_q     <= '0;
            full_q     <= 1'b0;
            rdy_q      <= 1'b0;
            sh_l_q     <= '0;
            sh_r_q     <= '0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            sdin_q     <= 1'b0;
            frm_strt_q <= 1'b0;
            undrn_q    <= 1'b0;
`ifndef I2S_ZERO_ON_UNDERRUN_EN
            prev_q     <= '0;
`endif
        end else begin
            sclk_q     <= SCLK;
            lrclk_q    <= LRCLK;
            hold_q     <= hold_d;
            full_q     <= full_d;
            rdy_q      <= rdy_d;
            sh_l_q     <= sh_l_d;
            sh_r_q     <= sh_r_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            sdin_q     <= sdin_d;
            frm_strt_q <= frm_strt_d;
            undrn_q    <= undrn_d;
`ifndef I2S_ZERO_ON_UNDERRUN_EN
            prev_q     <= prev_d;
`endif
        end
    end

    assign rdy      = rdy_q;
    assign SDin     = sdin_q;
    assign frm_strt = frm_strt_q;
    assign undrn    = undrn_q;

endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench for i2s_serializer: free-running SCLK/LRCLK generator, an I2S codec
// model that decodes SDin on rising SCLK, and hand-computed expected frames.
module tb_i2s_serializer;

    logic        clk, rst, SCLK, LRCLK, vld;
    logic [23:0] lft_in, rht_in;
    logic        rdy, SDin, frm_strt, undrn;

    int n_checks = 0;
    int n_fail   = 0;
    int p;
    int frm_cnt, frm_phase, und_cnt, und_phase, sdin_bad;

    typedef struct packed {
        logic        right;
        logic [23:0] word;
        logic        pad_nz;
    } slot_t;
    slot_t dec_q[$];

`ifdef I2S_ZERO_ON_UNDERRUN_EN
    localparam logic [23:0] UR_L = 24'h000000;
    localparam logic [23:0] UR_R = 24'h000000;
`else
    localparam logic [23:0] UR_L = 24'h123456;
    localparam logic [23:0] UR_R = 24'h654321;
`endif

    i2s_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .SCLK     (SCLK),
        .LRCLK    (LRCLK),
        .lft_in   (lft_in),
        .rht_in   (rht_in),
        .vld      (vld),
        .rdy      (rdy),
        .SDin     (SDin),
        .frm_strt (frm_strt),
        .undrn    (undrn)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Frame phase p: SCLK = clk/16, 64 SCLK per frame, LRCLK changes on falling SCLK at p=8 / p=520.
    initial begin
        p     = 0;
        SCLK  = 1'b1;
        LRCLK = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            p     = (p + 1) % 1024;
            SCLK  = ((p / 8) % 2) == 0;
            LRCLK = ((p + 1016) % 1024) >= 512;
        end
    end

    // Codec model: the first rising SCLK after an LRCLK edge carries bit 32 of the previous slot.
    initial begin
        logic        m_sclk, m_lr, m_pend, m_right, m_pad;
        logic        pend_ok, pend_right, pend_pad;
        logic [23:0] m_word, pend_word;
        int          m_idx;
        slot_t       s;
        m_sclk = 1'b1; m_lr = 1'b1; m_pend = 1'b0; m_right = 1'b1; m_pad = 1'b0;
        pend_ok = 1'b0; pend_right = 1'b0; pend_pad = 1'b0;
        m_word = '0; pend_word = '0; m_idx = 0;
        frm_cnt = 0; frm_phase = -1; und_cnt = 0; und_phase = -1;
        forever begin
            @(negedge clk);
            if (frm_strt === 1'b1) begin
                frm_cnt++;
                frm_phase = p;
            end
            if (undrn === 1'b1) begin
                und_cnt++;
                und_phase = p;
            end
            if (LRCLK !== m_lr) begin
                pend_word = m_word; pend_pad = m_pad; pend_right = m_right;
                pend_ok = (m_idx == 31); m_pend = 1'b1;
                m_idx = 0; m_word = '0; m_pad = 1'b0; m_right = LRCLK;
            end
            if (SCLK === 1'b1 && m_sclk === 1'b0) begin
                if (m_pend) begin
                    m_pend = 1'b0;
                    if (pend_ok) begin
                        s.right  = pend_right;
                        s.word   = pend_word;
                        s.pad_nz = pend_pad | (SDin !== 1'b0);
                        dec_q.push_back(s);
                    end
                end else if (m_idx < 31) begin
                    m_idx++;
                    if (m_idx <= 24) m_word = {m_word[22:0], SDin};
                    else if (SDin !== 1'b0) m_pad = 1'b1;
                end
            end
            m_sclk = SCLK;
            m_lr   = LRCLK;
        end
    end

    task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic skip_to(input int pt, input bit watch);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (watch && SDin !== 1'b0) sdin_bad++;
        end while (p != pt && n < 2100);
        if (p != pt) check("skip_to_timeout", 48'(p), 48'(pt));
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        int n;
        n = 0;
        lft_in = l;
        rht_in = r;
        vld    = 1'b1;
        while (rdy !== 1'b1 && n < 2100) begin
            @(posedge clk);
            #2;
            n++;
        end
        @(posedge clk);
        #2;
        vld = 1'b0;
        if (n >= 2100) check("send_timeout", 48'(n), 48'd0);
    endtask

    task automatic check_frame(input string tag, input logic [23:0] el, input logic [23:0] er);
        slot_t a, b;
        int    sz;
        sz = dec_q.size();
        if (sz < 2) begin
            check({tag, "_count"}, 48'(sz), 48'd2);
        end else begin
            a = dec_q[sz-2];
            b = dec_q[sz-1];
            check(tag, {a.word, b.word}, {el, er});
            check({tag, "_slot"}, 48'({a.right, b.right, a.pad_nz, b.pad_nz}), 48'(4'b0100));
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_a, r_b;
        logic [23:0] exp_l, exp_r;
        int          frm0, und0, und1, und2, bad, n;
        rst = 1'b1; vld = 1'b0; lft_in = '0; rht_in = '0; sdin_bad = 0;

        // Reset held with SCLK/LRCLK toggling; released while LRCLK is high.
        bad = 0;
        n   = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (SDin !== 1'b0 || rdy !== 1'b0) bad++;
        end while (p != 560 && n < 2100);
        check("rst_sdin_rdy_low", 48'(bad), 48'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("rst_release", 48'({rdy, SDin, frm_strt, undrn}), 48'(4'b1000));

        // Single frame.
        frm0 = frm_cnt;
        und0 = und_cnt;
        send_pair(24'hA5F00F, 24'h5A0FF0);
        check("rdy_low_after_accept", 48'(rdy), 48'd0);
        skip_to(8, 1'b0);
        r_a = rdy;
        skip_to(9, 1'b0);
        r_b = rdy;
        check("single_rdy_edge", 48'({r_a, r_b}), 48'(2'b01));
        skip_to(100, 1'b0);
        check("frm_strt_count", 48'(frm_cnt - frm0), 48'd1);
        check("frm_strt_phase", 48'(frm_phase), 48'd9);
        exp_l = 24'hA5F00F;
        exp_r = 24'h5A0FF0;

        // Back-to-back pairs 1..8, one per frame.
        for (int i = 1; i <= 8; i++) begin
            skip_to(600, 1'b0);
            send_pair(24'(i), 24'(i));
            skip_to(8, 1'b0);
            r_a = rdy;
            skip_to(9, 1'b0);
            r_b = rdy;
            check($sformatf("b2b_rdy%0d", i), 48'({r_a, r_b}), 48'(2'b01));
            skip_to(100, 1'b0);
            check_frame($sformatf("b2b_frame%0d", i), exp_l, exp_r);
            exp_l = 24'(i);
            exp_r = 24'(i);
        end
        check("b2b_no_undrn", 48'(und_cnt - und0), 48'd0);
        check("b2b_frm_count", 48'(frm_cnt - frm0), 48'd9);

        // Underrun: one pair, then a frame with no pair.
        skip_to(600, 1'b0);
        send_pair(24'h123456, 24'h654321);
        skip_to(100, 1'b0);
        check_frame("ur_last_b2b", 24'h000008, 24'h000008);
        und1 = und_cnt;
        skip_to(100, 1'b0);
        check_frame("ur_frame1", 24'h123456, 24'h654321);
        check("ur_undrn_count", 48'(und_cnt - und1), 48'd1);
        check("ur_undrn_phase", 48'(und_phase), 48'd9);
        skip_to(100, 1'b0);
        check_frame("ur_frame2", UR_L, UR_R);

        // Collision: vld on the lrclk_fall cycle while holding is empty.
        und2 = und_cnt;
        skip_to(8, 1'b0);
        lft_in = 24'h7FFFFF;
        rht_in = 24'h800000;
        vld    = 1'b1;
        r_a    = rdy;
        @(posedge clk);
        #2;
        vld = 1'b0;
        r_b = rdy;
        check("coll_rdy", 48'({r_a, r_b}), 48'(2'b10));
        skip_to(100, 1'b0);
        check("coll_undrn", 48'(und_cnt - und2), 48'd1);
        check_frame("coll_prev_frame", UR_L, UR_R);
        skip_to(100, 1'b0);
        check_frame("coll_underrun_frame", UR_L, UR_R);
        check("coll_undrn_once", 48'(und_cnt - und2), 48'd1);
        skip_to(100, 1'b0);
        check_frame("coll_pair_frame", 24'h7FFFFF, 24'h800000);

        // Mid-slot reset at left bit 10 with a pending pair that must be discarded.
        skip_to(120, 1'b0);
        send_pair(24'h111111, 24'h222222);
        skip_to(170, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("mid_rst_out", 48'({SDin, rdy}), 48'(2'b00));
        sdin_bad = 0;
        skip_to(300, 1'b1);
        send_pair(24'h0F0F0F, 24'hF0F0F0);
        skip_to(8, 1'b1);
        check("mid_rst_sdin_zero", 48'(sdin_bad), 48'd0);
        skip_to(100, 1'b0);
        skip_to(100, 1'b0);
        check_frame("mid_rst_frame", 24'h0F0F0F, 24'hF0F0F0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
